// File: rtl/mmio_uart_tx_if.sv
// I/O register bus between the memory stage and the UART transmitter:
// store strobe/data towards the UART, polled status word back.
interface mmio_uart_tx_if;
  logic        io_wr_en;
  logic [31:0] io_wr_data;
  logic [31:0] io_status;

  modport master (
    output io_wr_en,
    output io_wr_data,
    input  io_status
  );

  modport slave (
    input  io_wr_en,
    input  io_wr_data,
    output io_status
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO fed by I/O stores, serialiser FSM,
// registered status word {overflow, full, busy}.
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst,
  mmio_uart_tx_if.slave  bus,
  output logic           tx
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       status_q, status_d;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic full, empty, pop, push, baud_last, busy;
  logic unused_wr_data;

  assign unused_wr_data = ^bus.io_wr_data[31:8];

  assign full      = (count_q == CntW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign baud_last = (baud_q == BaudW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          bit_d   = '0;
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (baud_last) begin
          baud_d = '0;
          // Back-to-back: pop straight into the next start bit when data is waiting.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            bit_d   = '0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // A pop in the same cycle frees the slot, so a write to a full FIFO is still taken.
  assign push  = bus.io_wr_en && (!full || pop);
  assign ovf_d = ovf_q | (bus.io_wr_en && full && !pop);
  assign busy  = (state_q != StIdle) || !empty;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !push) count_d = count_q - CntW'(1);
  end

  assign status_d = {29'b0, ovf_q, full, busy};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      status_q <= status_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) mem_q[wr_ptr_q] <= bus.io_wr_data[7:0];
  end

  assign tx            = tx_q;
  assign bus.io_status = status_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised bench for mmio_uart_tx: timeline reference model plus a serial-line
// decoder that checks every frame against a scoreboard of accepted bytes.
module tb_mmio_uart_tx;

  localparam int C = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx;

  mmio_uart_tx_if bus_if ();

  mmio_uart_tx #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: pending bytes, current frame window, sticky overflow.
  logic [7:0] m_fifo[$];
  logic [7:0] m_cur;
  int         m_start, m_end;
  bit         m_idle = 1'b1;
  bit         m_ovf  = 1'b0;
  // Scoreboard: accepted bytes in order, and the edge each frame should start on.
  logic [7:0] sb_data[$];
  int         sb_start[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [31:0] exp_status;
    logic        exp_tx;
    bit          pop, was_full;
    int          k;
    cyc++;
    if (!rst) begin
      m_fifo.delete();
      sb_data.delete();
      sb_start.delete();
      m_idle     = 1'b1;
      m_ovf      = 1'b0;
      exp_status = '0;
    end else begin
      was_full   = (m_fifo.size() == D);
      exp_status = {29'b0, m_ovf, was_full, (!m_idle || m_fifo.size() != 0)};
      pop        = (m_fifo.size() != 0) && (m_idle || cyc == m_end);
      if (pop) begin
        m_cur   = m_fifo.pop_front();
        m_start = cyc;
        m_end   = cyc + 10 * C;
        m_idle  = 1'b0;
        sb_start.push_back(cyc);
      end else if (!m_idle && cyc == m_end) begin
        m_idle = 1'b1;
      end
      if (bus_if.io_wr_en) begin
        if (!was_full || pop) begin
          m_fifo.push_back(bus_if.io_wr_data[7:0]);
          sb_data.push_back(bus_if.io_wr_data[7:0]);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    exp_tx = 1'b1;
    if (!m_idle && cyc < m_end) begin
      k = (cyc - m_start) / C;
      if (k == 0)      exp_tx = 1'b0;
      else if (k <= 8) exp_tx = m_cur[k-1];
    end
    #1;
    check("tx_line", {31'b0, tx}, {31'b0, exp_tx});
    check("io_status", bus_if.io_status, exp_status);
  end

  // Serial-line monitor: decodes frames at mid-bit and retires scoreboard entries.
  bit         mon_active = 1'b0;
  int         mon_t0;
  logic [7:0] mon_byte;

  always @(posedge clk) begin
    int k, j;
    #2;
    if (!rst) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && tx == 1'b0) begin
        mon_active = 1'b1;
        mon_t0     = cyc;
        mon_byte   = '0;
      end
      if (mon_active) begin
        k = cyc - mon_t0;
        if (k % C == C / 2) begin
          j = k / C;
          if (j == 0) begin
            check("start_bit", {31'b0, tx}, 32'd0);
          end else if (j <= 8) begin
            mon_byte[j-1] = tx;
          end else begin
            check("stop_bit", {31'b0, tx}, 32'd1);
            mon_active = 1'b0;
            if (sb_data.size() == 0 || sb_start.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_frame cyc=%0d actual=0x%0h required=none", cyc, mon_byte);
            end else begin
              check("frame_data", {24'b0, mon_byte}, {24'b0, sb_data.pop_front()});
              check("frame_start", mon_t0, sb_start.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic drive(logic en, logic [31:0] d);
    @(negedge clk);
    bus_if.io_wr_en   = en;
    bus_if.io_wr_data = d;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, $urandom);
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    rst = 1'b0;
    bus_if.io_wr_en = 1'b0;
    repeat (n - 1) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus_if.io_wr_en   = 1'b0;
    bus_if.io_wr_data = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(20);

    // Single byte, upper bits ignored.
    drive(1'b1, 32'h0000_01A5);
    idle(50);

    // Back-to-back frames.
    drive(1'b1, 32'h55);
    drive(1'b1, 32'hAA);
    idle(90);

    // Overflow: sixth byte dropped, flag sticks until reset.
    for (int i = 1; i <= 6; i++) drive(1'b1, i);
    idle(5 * 10 * C + 20);
    do_reset(2);
    idle(5);

    // Fill, then write exactly on the STOP->START pop edge of the first frame.
    for (int i = 0; i < 5; i++) drive(1'b1, 32'hC0 + i);
    idle(10 * C + 1 - 5);
    drive(1'b1, 32'hE7);
    idle(6 * 10 * C + 20);

    // Reset during data bit 3 of 0x0F with two bytes queued.
    drive(1'b1, 32'h0F);
    drive(1'b1, 32'h11);
    drive(1'b1, 32'h22);
    idle(15);
    do_reset(2);
    idle(100);

    // Random bursts and gaps.
    for (int it = 0; it < 40; it++) begin
      int burst;
      burst = $urandom_range(1, 7);
      for (int b = 0; b < burst; b++) drive(($urandom_range(0, 3) != 0), $urandom);
      idle($urandom_range(0, 60));
    end
    idle(10 * C * (D + 2) + 20);

    n_tests++;
    if (sb_data.size() != 0) begin
      n_fail++;
      $display("FAIL drain cyc=%0d actual=%0d pending required=0", cyc, sb_data.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that sits directly downstream of the data-memory stage's memory-mapped I/O register. Each store to the I/O address produces a one-cycle write strobe with the store data; this block buffers the low byte in a small FIFO and serialises it as 8N1 frames on a single TX line. A status word is returned for software polling through the I/O read path.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range 2..65535.
- FIFO_DEPTH, default 4: byte entries in the TX FIFO. Must be a power of two, ≥2.

- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset: sampled on rising clk; 0 = reset.
- io_wr_en  input  1  one-cycle write strobe from the memory-mapped I/O store path.
- io_wr_data  input  32  store data; only bits [7:0] are transmitted, [31:8] ignored.
- tx  output  1  serial line, idle high, registered.
- io_status  output  32  {29'b0, overflow, full, busy}, registered.

## Operation
- FIFO: write pointer, read pointer and count register (width clog2(FIFO_DEPTH)+1). full = (count == FIFO_DEPTH); empty = (count == 0).
- Push: io_wr_en=1 and not full → io_wr_data[7:0] written, count+1.
- Push while full → byte dropped, overflow set. overflow is sticky; it clears only on reset.
- Simultaneous push and pop while full → pop frees a slot, push accepted, overflow not set, count unchanged.
- Simultaneous push and pop while empty is impossible: a pop requires non-empty at the edge.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If not empty, pop the head byte into the shift register, clear the bit counter, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = shift[0], LSB first. Every CLKS_PER_BIT cycles, shift right and increment the bit counter. After the 8th bit, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end of STOP:
    - if not empty, pop and go directly to START (back-to-back, no idle cycles);
    - otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1; wraps and advances the bit on reaching CLKS_PER_BIT-1. It is reset to 0 on every state entry.
- busy = 1 in any state other than IDLE, or when the FIFO is not empty.
- Reset (rst=0 at an edge), including mid-frame:
  - state=IDLE, tx=1;
  - FIFO pointers and count cleared (contents discarded);
  - overflow=0, io_status=0.
  - A frame in progress is abandoned; no partial completion.

## Timing
- Push latency: a byte written at edge E0 is counted at E0.
- From IDLE: pop and START entry at E1 = E0+1. tx falls after E1 and busy=1 from E0+1.
- Frame length: exactly 10×CLKS_PER_BIT cycles (start, 8 data, stop).
- Back-to-back frames: the next start bit begins on the cycle after the last stop-bit cycle.
- io_status is updated one cycle after the causing event; io_wr_en at E0 to a full FIFO shows overflow=1 after E0+1.
- io_wr_en strobes may arrive every cycle. The block never stalls the producer; excess bytes are dropped and flagged.

## Test plan
- Reset: hold rst=0 for 3 cycles, release → tx=1, io_status=0x0 on every cycle; tx stays 1 with no writes.
- Single byte, CLKS_PER_BIT=4: write 0x0000_01A5 →
  - tx samples at mid-bit = 0, 1,0,1,0,0,1,0,1, 1 (0xA5 LSB first);
  - frame is 40 cycles, starting 1 cycle after the write;
  - busy=1 throughout, then 0 in IDLE.
- Back-to-back, CLKS_PER_BIT=4: write 0x55 then 0xAA on consecutive cycles → two frames totalling 80 cycles with no idle-high gap between the first stop bit and the second start bit.
- Overflow, FIFO_DEPTH=4, CLKS_PER_BIT=4: six writes on consecutive cycles 0x01..0x06 →
  - the first is popped at the cycle after its write;
  - 0x01..0x05 are transmitted, 0x06 is dropped;
  - io_status = 0x7 (overflow|full|busy) after the sixth write;
  - overflow remains set after the line goes idle (io_status=0x4).
- Push with pop while full: fill the FIFO, then strobe a write on the exact cycle the STOP→START pop occurs → byte accepted, overflow stays 0, all bytes transmitted in order.
- Reset mid-frame: assert rst=0 during DATA bit 3 of 0x0F with two bytes queued → tx=1 on the next cycle, io_status=0, and no further frames after reset release.
